hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Central hazard and forwarding controller for the 5-stage pipeline (F/D, D/X, X/M, M/W).
//  Replaces the per-signal bypass and stall equations in the top level with one block.
//  Forwarding selects are registered at the D->X boundary. It adds a configurable
//  multi-cycle data-memory latency freeze, branch flush, and a stall-cycle counter.
// PARAMETERS
//  REG_ADDR_W  5  register specifier width
//  LOAD_LAT    1  extra DMEM cycles per load in M (0..3); pipeline frozen this many cycles
//  BYPASS_EN   1  1 = MX/WX forwarding; 0 = interlock-only (stall on any RAW vs X or M)
// PORTS
//  clock        in   1           pipeline clock, posedge
//  reset        in   1           asynchronous, active-high
//  d_valid      in   1           F/D holds a real instruction
//  d_rs         in   REG_ADDR_W  F/D source A (insn[25:21])
//  d_rt         in   REG_ADDR_W  F/D source B (insn[20:16])
//  d_uses_rt    in   1           rt is a true source of the F/D instruction
//  x_valid      in   1           D/X holds a real instruction
//  x_rd         in   REG_ADDR_W  D/X destination after rdst mux
//  x_rwe        in   1           D/X writes the register file
//  x_is_load    in   1           D/X is LW/LB
//  m_valid      in   1           X/M holds a real instruction
//  m_rd         in   REG_ADDR_W  X/M destination
//  m_rwe        in   1           X/M writes the register file
//  m_is_load    in   1           X/M is LW/LB
//  do_branch    in   1           execute resolved a taken branch/jump this cycle
//  fwd_a        out  2           operand A select for X: 00 RF, 01 MX (aluOut_XM), 10 WX (dataout)
//  fwd_b        out  2           operand B select for X, same encoding
//  stall_fd     out  1           hold PC and F/D; inject bubble into D/X
//  stall_all    out  1           freeze PC and all pipeline registers
//  flush        out  1           squash F/D and D/X (write bubbles)
//  stall_cycles out  16          saturating count of cycles with stall_fd|stall_all
// BEHAVIOUR
//  - Register 0 never matches: any rd==0 or rwe==0 producer is ignored.
//  - match_x(s) = x_valid & x_rwe & x_rd!=0 & x_rd==s; match_m(s) likewise on m_*.
//  - srcA = d_rs when d_valid; srcB = d_rt when d_valid & d_uses_rt.
//  - raw_lu = match_x(srcA) | match_x(srcB), with x_is_load set.
//  - BYPASS_EN=1: stall_fd_raw = raw_lu.
//  - BYPASS_EN=0: stall_fd_raw = any match_x or match_m on srcA/srcB. The RF is
//    write-before-read, so the W stage never stalls.
//  - Priority: stall_all > flush > stall_fd.
//    - flush = do_branch & x_valid & ~stall_all.
//    - stall_fd = stall_fd_raw & ~flush & ~stall_all.
//    - The branch is held while frozen and re-asserts after.
//  - Forward select registers, updated at posedge:
//    - stall_all: hold.
//    - flush or stall_fd: load 00 (bubble).
//    - otherwise: 01 if BYPASS_EN & match_x(src); else 10 if BYPASS_EN & match_m(src); else 00.
//    - An X-stage producer is younger, so it wins over an M-stage producer.
//  - Load-latency FSM, states IDLE and WAIT, 2-bit counter cnt:
//    - IDLE: on m_valid & m_is_load & LOAD_LAT!=0, stall_all=1 (combinational),
//      then go to WAIT with cnt=LOAD_LAT-1.
//    - WAIT: stall_all = (cnt!=0); cnt decrements. At cnt==0, stall_all=0, the
//      pipeline advances, and the FSM returns to IDLE. The same load never retriggers.
//    - Freeze length is exactly LOAD_LAT cycles per load.
//    - A load-use stall_fd behind a frozen load is evaluated only after the freeze.
//  - stall_cycles: +1 per cycle with stall_fd|stall_all; saturates at 16'hFFFF.
//  - Reset, asynchronous: state=IDLE, cnt=0, fwd_a=fwd_b=00, stall_cycles=0.
//    - stall_fd, stall_all and flush are forced to 0 while reset=1.
//    - Reset mid-WAIT abandons the freeze immediately.
// TESTING
//  1. x_rd=3,x_rwe=1, d_rs=3 -> stall_fd=0; next cycle fwd_a=01.
//     Add m_rd=3 too -> still 01 (X wins).
//  2. x_is_load, x_rd=5, d_rt=5, d_uses_rt=1 -> stall_fd=1 one cycle, fwd_b=00.
//     Next cycle: load in M, LOAD_LAT=0 -> fwd_b=10.
//  3. LOAD_LAT=2, m_is_load=1 -> stall_all=1 exactly 2 cycles; fwd_a/fwd_b held;
//     stall_cycles +=2.
//  4. do_branch=1 with a load-use match -> flush=1, stall_fd=0, fwd_*=00 next.
//     Same with stall_all=1 -> flush=0.
//  5. x_rd=0,x_rwe=1, d_rs=0 -> no stall, fwd_a=00.
//     BYPASS_EN=0 with m_rd=4, d_rs=4 -> stall_fd=1.
//  6. Assert reset during WAIT -> stall_all=0 in the same cycle; after release:
//     IDLE, stall_cycles=0, fwd=00.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Central hazard and forwarding controller for the 5-stage pipeline
//   (F/D, D/X, X/M, M/W). It decides the stalls, flushes and operand
//   forwarding for the pipeline in one place:
//     - RAW detection of the F/D sources against the D/X and X/M producers
//     - load-use interlock, or a full interlock when bypassing is disabled
//     - forwarding selects, registered at the D->X boundary
//     - a freeze of the whole pipeline while a multi-cycle data-memory load
//       in M completes (LOAD_LAT extra cycles per load)
//     - branch flush of F/D and D/X
//     - a saturating count of stalled cycles
//
// Parameters
//   REG_ADDR_W  register specifier width
//   LOAD_LAT    extra DMEM cycles per load in M (0..3)
//   BYPASS_EN   1 = MX/WX forwarding, 0 = interlock only
//
// Ports
//   clock        in   pipeline clock, posedge
//   reset        in   asynchronous, active-high
//   d_valid      in   F/D holds a real instruction
//   d_rs, d_rt   in   F/D source specifiers
//   d_uses_rt    in   rt is a true source of the F/D instruction
//   x_valid      in   D/X holds a real instruction
//   x_rd         in   D/X destination
//   x_rwe        in   D/X writes the register file
//   x_is_load    in   D/X is a load
//   m_valid      in   X/M holds a real instruction
//   m_rd         in   X/M destination
//   m_rwe        in   X/M writes the register file
//   m_is_load    in   X/M is a load
//   do_branch    in   execute resolved a taken branch/jump this cycle
//   fwd_a, fwd_b out  operand select for X: 00 RF, 01 MX, 10 WX
//   stall_fd     out  hold PC and F/D, bubble into D/X
//   stall_all    out  freeze PC and all pipeline registers
//   flush        out  squash F/D and D/X
//   stall_cycles out  saturating count of cycles with stall_fd|stall_all
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter bit BYPASS_EN  = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  d_valid,
    input  logic [REG_ADDR_W-1:0] d_rs,
    input  logic [REG_ADDR_W-1:0] d_rt,
    input  logic                  d_uses_rt,
    input  logic                  x_valid,
    input  logic [REG_ADDR_W-1:0] x_rd,
    input  logic                  x_rwe,
    input  logic                  x_is_load,
    input  logic                  m_valid,
    input  logic [REG_ADDR_W-1:0] m_rd,
    input  logic                  m_rwe,
    input  logic                  m_is_load,
    input  logic                  do_branch,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  stall_fd,
    output logic                  stall_all,
    output logic                  flush,
    output logic [15:0]           stall_cycles
);

    localparam bit       LAT_EN   = (LOAD_LAT != 0);
    localparam logic [1:0] CNT_INIT = (LOAD_LAT == 0) ? 2'd0 : 2'(LOAD_LAT - 1);

    localparam logic [1:0] SEL_RF = 2'b00;
    localparam logic [1:0] SEL_MX = 2'b01;
    localparam logic [1:0] SEL_WX = 2'b10;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } lat_state_t;

    lat_state_t state;
    logic [1:0] cnt;

    logic src_a_en;
    logic src_b_en;
    logic hit_xa;
    logic hit_xb;
    logic hit_ma;
    logic hit_mb;
    logic raw_lu;
    logic stall_fd_raw;
    logic load_in_m;
    logic freeze;
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    // Producer matching. Register 0 and non-writing producers never match,
    // and rt only counts when the decoding instruction really reads it.
    always_comb begin
        src_a_en = d_valid;
        src_b_en = d_valid & d_uses_rt;

        hit_xa = src_a_en & x_valid & x_rwe & (x_rd != '0) & (x_rd == d_rs);
        hit_xb = src_b_en & x_valid & x_rwe & (x_rd != '0) & (x_rd == d_rt);
        hit_ma = src_a_en & m_valid & m_rwe & (m_rd != '0) & (m_rd == d_rs);
        hit_mb = src_b_en & m_valid & m_rwe & (m_rd != '0) & (m_rd == d_rt);

        raw_lu = x_is_load & (hit_xa | hit_xb);

        // Without bypassing any in-flight producer in X or M blocks decode;
        // W is covered by the write-before-read register file.
        if (BYPASS_EN) begin
            stall_fd_raw = raw_lu;
        end else begin
            stall_fd_raw = hit_xa | hit_xb | hit_ma | hit_mb;
        end
    end

    // Hazard outputs with priority stall_all > flush > stall_fd. The freeze
    // is raised in the very cycle a load reaches M, so it has to be
    // combinational from the FSM state. A branch or load-use held behind a
    // freeze simply re-evaluates once the freeze drops.
    always_comb begin
        load_in_m = m_valid & m_is_load;
        freeze    = 1'b0;
        if (LAT_EN) begin
            if (state == ST_IDLE) begin
                freeze = load_in_m;
            end else begin
                freeze = (cnt != 2'd0);
            end
        end

        stall_all = ~reset & freeze;
        flush     = ~reset & do_branch & x_valid & ~stall_all;
        stall_fd  = ~reset & stall_fd_raw & ~flush & ~stall_all;
    end

    // Forward selects for the instruction entering X. The X-stage producer
    // is the younger one, so it wins over the M-stage producer.
    always_comb begin
        sel_a = SEL_RF;
        sel_b = SEL_RF;
        if (BYPASS_EN) begin
            if (hit_xa) begin
                sel_a = SEL_MX;
            end else if (hit_ma) begin
                sel_a = SEL_WX;
            end
            if (hit_xb) begin
                sel_b = SEL_MX;
            end else if (hit_mb) begin
                sel_b = SEL_WX;
            end
        end
    end

    // Selects are registered at the D->X boundary; a bubble entering X
    // (flush or decode stall) reads the register file.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fwd_a <= SEL_RF;
            fwd_b <= SEL_RF;
        end else if (stall_all) begin
            fwd_a <= fwd_a;
            fwd_b <= fwd_b;
        end else if (flush || stall_fd) begin
            fwd_a <= SEL_RF;
            fwd_b <= SEL_RF;
        end else begin
            fwd_a <= sel_a;
            fwd_b <= sel_b;
        end
    end

    // Load-latency FSM. Entering WAIT with cnt=LOAD_LAT-1 gives exactly
    // LOAD_LAT frozen cycles; the cnt==0 cycle releases the pipeline and
    // does not look at M, so the same load cannot retrigger.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (LAT_EN && load_in_m) begin
                        state <= ST_WAIT;
                        cnt   <= CNT_INIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 2'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles <= 16'd0;
        end else if ((stall_fd || stall_all) && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule
